cr_vga: RTL and testbench
=========================

// Module: cr_vga
// PURPOSE
//  640x480 @ 60 Hz VGA timing generator and colour gate for the Spartan-3E board (50 MHz clock, 1-bit-per-channel DAC).
//  Produces negative-polarity hoz_sync/ver_sync and the current pixel column/row for an upstream pattern source.
//  Passes the source's R/G/B through during the visible area and forces black during blanking.
//  Sits between the pattern/state-machine logic and the VGA connector pins.
// PARAMETERS
//  CLK_DIV    2    system clocks per pixel (50 MHz -> 25 MHz pixel rate); must be >= 1
//  H_VISIBLE  640  visible pixels per line
//  H_FRONT    16   horizontal front porch, pixels
//  H_SYNC     96   horizontal sync pulse, pixels
//  H_BACK     48   horizontal back porch, pixels (H_TOTAL = 800)
//  V_VISIBLE  480  visible lines per frame
//  V_FRONT    10   vertical front porch, lines
//  V_SYNC     2    vertical sync pulse, lines
//  V_BACK     33   vertical back porch, lines (V_TOTAL = 525)
//  COORD_W    10   width of the column/row outputs
// PORTS
//  clock        in   1        system clock, 50 MHz
//  reset        in   1        asynchronous, active-low reset
//  iCrvgaR      in   1        red request for the current pixel
//  iCrvgaG      in   1        green request for the current pixel
//  iCrvgaB      in   1        blue request for the current pixel
//  oCrvgaR      out  1        red to the connector, black when blanked
//  oCrvgaG      out  1        green to the connector, black when blanked
//  oCrvgaB      out  1        blue to the connector, black when blanked
//  hoz_sync     out  1        horizontal sync, active low
//  ver_sync     out  1        vertical sync, active low
//  oCurrentCol  out  COORD_W  horizontal counter, 0..H_TOTAL-1
//  oCurrentRow  out  COORD_W  vertical counter, 0..V_TOTAL-1
// BEHAVIOUR
//  - Reset (reset=0, async): div, col and row counters = 0, hoz_sync = ver_sync = 1, oCrvgaR/G/B = 0. Release is synchronous to the next clock.
//  - Pixel tick: the div counter counts 0..CLK_DIV-1 every clock and then wraps. tick = (div == CLK_DIV-1).
//  - On tick: col increments. At col == H_TOTAL-1 col wraps to 0 and row increments. At row == V_TOTAL-1 with col wrapping, row wraps to 0.
//  - oCurrentCol/oCurrentRow are the counter registers themselves (no latency). Row 0/col 0 = first visible pixel of a frame.
//  - visible = (col < H_VISIBLE) && (row < V_VISIBLE).
//  - Outputs are registered every clock from the current counters, 1-clock latency versus col/row:
//      hoz_sync <= ~(col >= H_VISIBLE+H_FRONT && col < H_VISIBLE+H_FRONT+H_SYNC)  (low for cols 656..751)
//      ver_sync <= ~(row >= V_VISIBLE+V_FRONT && row < V_VISIBLE+V_FRONT+V_SYNC)  (low for rows 490..491)
//      {oCrvgaR,oCrvgaG,oCrvgaB} <= visible ? {iCrvgaR,iCrvgaG,iCrvgaB} : 3'b000
//  - Colour inputs are sampled every clock. A change mid-pixel takes effect on the following clock.
//  - Reset mid-frame: counters restart at 0,0 immediately. The next frame is a full frame, not a partial one.
//  - Counter arithmetic is unsigned, COORD_W bits. Parameters must give H_TOTAL, V_TOTAL <= 2**COORD_W.
// CONFIGURATION
//  CRVGA_TEST_PATTERN_EN defined: the iCrvga* inputs are ignored. The visible colour is eight vertical bars, 80 columns each,
//   colour = col[9:7]-style index (col/80) mapped to {R,G,B} = index[2:0]. Blanking and sync are unchanged.
//  Not defined: the colour is taken from iCrvgaR/G/B as specified above.
// STRUCTURE
//  Package crvga_pkg: default timing constants (H_/V_ visible, porch, sync, total), COORD_W, and colour codes
//   (COLOR_BLACK=3'b000, RED=3'b100, GREEN=3'b010, BLUE=3'b001, MAGENTA=3'b101) as {R,G,B}.
//  One sub-module crvga_axis_counter (wrapping counter with enable, terminal-count output), instantiated
//   twice: col (enable=tick) and row (enable=tick & col terminal count).
// TESTING
//  1 Hold reset low 5 clocks, release -> col=row=0, hoz_sync=ver_sync=1, RGB=0. Col becomes 1 after CLK_DIV clocks.
//  2 Free-run one line -> hoz_sync low for exactly 96*CLK_DIV=192 clocks, starting 1 clock after col reaches 656.
//    Line period is 1600 clocks.
//  3 Free-run one frame -> ver_sync low for 2 lines (3200 clocks) starting at row 490.
//    Frame period is 525*1600=840000 clocks. Row wraps 524->0.
//  4 Drive iCrvga*=3'b111 constantly -> RGB=111 only while col<640 && row<480 (1-clock lag), else 000.
//  5 Assert reset at row 300 col 200 -> all outputs reach their reset values asynchronously.
//    After release, counting restarts at 0,0.
//  6 With CRVGA_TEST_PATTERN_EN, inputs tied 0 -> col 0..79 black, col 80..159 blue, ..., col 560..639 white.

Source files
------------

// File: rtl/crvga_pkg.sv
// Shared timing defaults and {R,G,B} colour codes for the cr_vga timing generator.
package crvga_pkg;

   localparam int unsigned DEF_CLK_DIV   = 2;
   localparam int unsigned DEF_H_VISIBLE = 640;
   localparam int unsigned DEF_H_FRONT   = 16;
   localparam int unsigned DEF_H_SYNC    = 96;
   localparam int unsigned DEF_H_BACK    = 48;
   localparam int unsigned DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int unsigned DEF_V_VISIBLE = 480;
   localparam int unsigned DEF_V_FRONT   = 10;
   localparam int unsigned DEF_V_SYNC    = 2;
   localparam int unsigned DEF_V_BACK    = 33;
   localparam int unsigned DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
   localparam int unsigned DEF_COORD_W   = 10;

   typedef logic [2:0] rgb_t;

   localparam rgb_t COLOR_BLACK   = 3'b000;
   localparam rgb_t COLOR_RED     = 3'b100;
   localparam rgb_t COLOR_GREEN   = 3'b010;
   localparam rgb_t COLOR_BLUE    = 3'b001;
   localparam rgb_t COLOR_MAGENTA = 3'b101;

   // Bar index doubles as the {R,G,B} code: bar 0 black, bar 1 blue, ..., bar 7 white.
   function automatic rgb_t bar_color(input int unsigned col, input int unsigned bar_w);
      return rgb_t'(col / bar_w);
   endfunction

endpackage

// File: rtl/crvga_axis_counter.sv
// Wrapping 0..TOTAL-1 counter with enable and a terminal-count flag; used for VGA col and row.
module crvga_axis_counter #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned TOTAL = 800
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             last
);

   assign last = (32'(count) == TOTAL - 1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (enable) begin
         count <= last ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/cr_vga.sv
// 640x480@60 VGA timing generator and colour gate; define CRVGA_TEST_PATTERN_EN to replace the
// iCrvga* inputs with eight built-in vertical colour bars.
module cr_vga
   import crvga_pkg::*;
#(
   parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
   parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
   parameter int unsigned H_FRONT   = DEF_H_FRONT,
   parameter int unsigned H_SYNC    = DEF_H_SYNC,
   parameter int unsigned H_BACK    = DEF_H_BACK,
   parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
   parameter int unsigned V_FRONT   = DEF_V_FRONT,
   parameter int unsigned V_SYNC    = DEF_V_SYNC,
   parameter int unsigned V_BACK    = DEF_V_BACK,
   parameter int unsigned COORD_W   = DEF_COORD_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               iCrvgaR,
   input  logic               iCrvgaG,
   input  logic               iCrvgaB,
   output logic               oCrvgaR,
   output logic               oCrvgaG,
   output logic               oCrvgaB,
   output logic               hoz_sync,
   output logic               ver_sync,
   output logic [COORD_W-1:0] oCurrentCol,
   output logic [COORD_W-1:0] oCurrentRow
);

   localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
   localparam int unsigned DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0]   div;
   logic               tick;
   logic [COORD_W-1:0] col;
   logic [COORD_W-1:0] row;
   logic               col_last;
   logic               unused_row_last;
   logic               visible;
   logic               h_active;
   logic               v_active;
   rgb_t               src_rgb;
   rgb_t               out_rgb;

   assign tick = (32'(div) == CLK_DIV - 1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         div <= '0;
      end else begin
         div <= tick ? '0 : div + 1'b1;
      end
   end

   crvga_axis_counter #(
      .WIDTH (COORD_W),
      .TOTAL (H_TOTAL)
   ) u_col (
      .clock  (clock),
      .reset  (reset),
      .enable (tick),
      .count  (col),
      .last   (col_last)
   );

   crvga_axis_counter #(
      .WIDTH (COORD_W),
      .TOTAL (V_TOTAL)
   ) u_row (
      .clock  (clock),
      .reset  (reset),
      .enable (tick & col_last),
      .count  (row),
      .last   (unused_row_last)
   );

   assign oCurrentCol = col;
   assign oCurrentRow = row;

   always_comb begin
      visible  = (32'(col) < H_VISIBLE) && (32'(row) < V_VISIBLE);
      h_active = (32'(col) >= H_SYNC_START) && (32'(col) < H_SYNC_END);
      v_active = (32'(row) >= V_SYNC_START) && (32'(row) < V_SYNC_END);
`ifdef CRVGA_TEST_PATTERN_EN
      src_rgb  = bar_color(32'(col), H_VISIBLE / 8);
`else
      src_rgb  = {iCrvgaR, iCrvgaG, iCrvgaB};
`endif
   end

`ifdef CRVGA_TEST_PATTERN_EN
   logic unused_inputs;
   assign unused_inputs = ^{iCrvgaR, iCrvgaG, iCrvgaB};
`endif

   // Registered outputs lag col/row by one clock; this absorbs the compare logic glitches.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hoz_sync <= 1'b1;
         ver_sync <= 1'b1;
         out_rgb  <= COLOR_BLACK;
      end else begin
         hoz_sync <= ~h_active;
         ver_sync <= ~v_active;
         out_rgb  <= visible ? src_rgb : COLOR_BLACK;
      end
   end

   assign {oCrvgaR, oCrvgaG, oCrvgaB} = out_rgb;

endmodule

// File: tb/tb_cr_vga.sv
// Directed bench for cr_vga: default horizontal timing, shortened vertical timing to keep runs short.
module tb_cr_vga;

   localparam int unsigned CLK_DIV   = 2;
   localparam int unsigned H_VISIBLE = 640;
   localparam int unsigned H_FRONT   = 16;
   localparam int unsigned H_SYNC    = 96;
   localparam int unsigned H_BACK    = 48;
   localparam int unsigned V_VISIBLE = 4;
   localparam int unsigned V_FRONT   = 1;
   localparam int unsigned V_SYNC    = 2;
   localparam int unsigned V_BACK    = 1;
   localparam int unsigned COORD_W   = 10;
   localparam int unsigned H_TOTAL   = 800;
   localparam int unsigned V_TOTAL   = 8;
   localparam int unsigned LINE_CLKS = H_TOTAL * CLK_DIV;

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   logic               in_r = 1'b0;
   logic               in_g = 1'b0;
   logic               in_b = 1'b0;
   logic               out_r;
   logic               out_g;
   logic               out_b;
   logic               hoz;
   logic               ver;
   logic [COORD_W-1:0] col;
   logic [COORD_W-1:0] row;
   logic [2:0]         rgb;

   int errors = 0;
   int checks = 0;

   assign rgb = {out_r, out_g, out_b};

   always #5 clock = ~clock;

   cr_vga #(
      .CLK_DIV   (CLK_DIV),
      .H_VISIBLE (H_VISIBLE),
      .H_FRONT   (H_FRONT),
      .H_SYNC    (H_SYNC),
      .H_BACK    (H_BACK),
      .V_VISIBLE (V_VISIBLE),
      .V_FRONT   (V_FRONT),
      .V_SYNC    (V_SYNC),
      .V_BACK    (V_BACK),
      .COORD_W   (COORD_W)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .iCrvgaR     (in_r),
      .iCrvgaG     (in_g),
      .iCrvgaB     (in_b),
      .oCrvgaR     (out_r),
      .oCrvgaG     (out_g),
      .oCrvgaB     (out_b),
      .hoz_sync    (hoz),
      .ver_sync    (ver),
      .oCurrentCol (col),
      .oCurrentRow (row)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic set_rgb(input logic [2:0] c);
      {in_r, in_g, in_b} = c;
   endtask

   task automatic wait_col(input int unsigned target, output int unsigned clks);
      clks = 0;
      do begin
         step(1);
         clks++;
      end while (col !== target && clks < 2 * LINE_CLKS);
      checks++;
      if (col !== target) begin
         errors++;
         $display("FAIL wait_col: col=%0d required %0d within %0d clocks", col, target, clks);
      end
   endtask

   task automatic wait_row(input int unsigned target, output int unsigned clks);
      clks = 0;
      do begin
         step(1);
         clks++;
      end while (row !== target && clks < 2 * V_TOTAL * LINE_CLKS);
      checks++;
      if (row !== target) begin
         errors++;
         $display("FAIL wait_row: row=%0d required %0d within %0d clocks", row, target, clks);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      set_rgb(3'b000);
      step(5);
      checks++; if (col !== 0) begin errors++; $display("FAIL reset_col: got %0d want 0", col); end
      checks++; if (row !== 0) begin errors++; $display("FAIL reset_row: got %0d want 0", row); end
      checks++; if (hoz !== 1'b1) begin errors++; $display("FAIL reset_hoz: got %b want 1", hoz); end
      checks++; if (ver !== 1'b1) begin errors++; $display("FAIL reset_ver: got %b want 1", ver); end
      checks++; if (rgb !== 3'b000) begin errors++; $display("FAIL reset_rgb: got %b want 000", rgb); end
      reset = 1'b1;
      step(1);
      checks++; if (col !== 0) begin errors++; $display("FAIL release_col0: got %0d want 0", col); end
      step(1);
      checks++; if (col !== 1) begin errors++; $display("FAIL release_col1: got %0d want 1", col); end
      checks++; if (row !== 0) begin errors++; $display("FAIL release_row: got %0d want 0", row); end
   endtask

   task automatic test_line;
      int unsigned n;
      int unsigned a;
      int unsigned b;
      int unsigned low;
      wait_col(656, n);
      checks++; if (hoz !== 1'b1) begin errors++; $display("FAIL hsync_lag: got %b want 1", hoz); end
      step(1);
      checks++; if (hoz !== 1'b0) begin errors++; $display("FAIL hsync_start: got %b want 0", hoz); end
      low = 0;
      while (hoz === 1'b0 && low < LINE_CLKS) begin
         low++;
         step(1);
      end
      checks++;
      if (low != H_SYNC * CLK_DIV) begin
         errors++; $display("FAIL hsync_width: got %0d want %0d", low, H_SYNC * CLK_DIV);
      end
      checks++; if (col !== 752) begin errors++; $display("FAIL hsync_end_col: got %0d want 752", col); end
      wait_col(0, n);
      wait_col(1, a);
      wait_col(0, b);
      checks++;
      if (a + b != LINE_CLKS) begin
         errors++; $display("FAIL line_period: got %0d want %0d", a + b, LINE_CLKS);
      end
   endtask

   task automatic test_frame;
      int unsigned n;
      int unsigned a;
      int unsigned b;
      int unsigned low;
      wait_row(V_VISIBLE + V_FRONT, n);
      checks++; if (ver !== 1'b1) begin errors++; $display("FAIL vsync_lag: got %b want 1", ver); end
      checks++; if (col !== 0) begin errors++; $display("FAIL vsync_row_col: got %0d want 0", col); end
      step(1);
      checks++; if (ver !== 1'b0) begin errors++; $display("FAIL vsync_start: got %b want 0", ver); end
      low = 0;
      while (ver === 1'b0 && low < 4 * LINE_CLKS) begin
         low++;
         step(1);
      end
      checks++;
      if (low != V_SYNC * LINE_CLKS) begin
         errors++; $display("FAIL vsync_width: got %0d want %0d", low, V_SYNC * LINE_CLKS);
      end
      checks++; if (row !== 7) begin errors++; $display("FAIL vsync_end_row: got %0d want 7", row); end
      wait_row(0, n);
      checks++; if (col !== 0) begin errors++; $display("FAIL frame_wrap_col: got %0d want 0", col); end
      wait_row(1, a);
      wait_row(0, b);
      checks++;
      if (a + b != V_TOTAL * LINE_CLKS) begin
         errors++; $display("FAIL frame_period: got %0d want %0d", a + b, V_TOTAL * LINE_CLKS);
      end
   endtask

`ifndef CRVGA_TEST_PATTERN_EN
   // Entered at the first clock of row 0 / col 0.
   task automatic test_colour;
      int unsigned n;
      checks++; if (rgb !== 3'b000) begin errors++; $display("FAIL rgb_prev_blank: got %b want 000", rgb); end
      set_rgb(3'b111);
      step(1);
      checks++; if (rgb !== 3'b111) begin errors++; $display("FAIL rgb_first_pix: got %b want 111", rgb); end
      set_rgb(3'b101);
      step(1);
      checks++; if (rgb !== 3'b101) begin errors++; $display("FAIL rgb_mid_pixel: got %b want 101", rgb); end
      set_rgb(3'b111);
      wait_col(640, n);
      checks++; if (rgb !== 3'b111) begin errors++; $display("FAIL rgb_col639: got %b want 111", rgb); end
      step(1);
      checks++; if (rgb !== 3'b000) begin errors++; $display("FAIL rgb_col640: got %b want 000", rgb); end
      wait_row(V_VISIBLE - 1, n);
      step(1);
      checks++; if (rgb !== 3'b111) begin errors++; $display("FAIL rgb_last_row: got %b want 111", rgb); end
      wait_row(V_VISIBLE, n);
      step(1);
      checks++; if (rgb !== 3'b000) begin errors++; $display("FAIL rgb_vblank: got %b want 000", rgb); end
   endtask
`else
   task automatic test_pattern;
      int unsigned n;
      set_rgb(3'b000);
      step(1);
      checks++; if (rgb !== 3'b000) begin errors++; $display("FAIL bar0: got %b want 000", rgb); end
      for (int bar = 1; bar < 8; bar++) begin
         wait_col(bar * 80, n);
         step(1);
         checks++;
         if (rgb !== bar[2:0]) begin
            errors++; $display("FAIL bar%0d: got %b want %b", bar, rgb, bar[2:0]);
         end
      end
      wait_col(640, n);
      step(1);
      checks++; if (rgb !== 3'b000) begin errors++; $display("FAIL bar_blank: got %b want 000", rgb); end
   endtask
`endif

   task automatic test_reset_mid;
      int unsigned n;
      set_rgb(3'b111);
      wait_row(2, n);
      wait_col(200, n);
`ifndef CRVGA_TEST_PATTERN_EN
      checks++; if (rgb !== 3'b111) begin errors++; $display("FAIL mid_pre_rgb: got %b want 111", rgb); end
`else
      checks++; if (rgb !== 3'b010) begin errors++; $display("FAIL mid_pre_rgb: got %b want 010", rgb); end
`endif
      reset = 1'b0;
      #1;
      checks++; if (col !== 0) begin errors++; $display("FAIL mid_rst_col: got %0d want 0", col); end
      checks++; if (row !== 0) begin errors++; $display("FAIL mid_rst_row: got %0d want 0", row); end
      checks++; if (rgb !== 3'b000) begin errors++; $display("FAIL mid_rst_rgb: got %b want 000", rgb); end
      step(3);
      reset = 1'b1;
      step(2);
      checks++; if (col !== 1) begin errors++; $display("FAIL mid_restart_col: got %0d want 1", col); end
      checks++; if (row !== 0) begin errors++; $display("FAIL mid_restart_row: got %0d want 0", row); end
      wait_row(1, n);
      checks++;
      if (n != LINE_CLKS - 2) begin
         errors++; $display("FAIL mid_first_line: got %0d want %0d", n, LINE_CLKS - 2);
      end
      // Second reset lands inside both sync pulses.
      wait_row(V_VISIBLE + V_FRONT, n);
      wait_col(700, n);
      checks++; if (hoz !== 1'b0) begin errors++; $display("FAIL sync_pre_hoz: got %b want 0", hoz); end
      checks++; if (ver !== 1'b0) begin errors++; $display("FAIL sync_pre_ver: got %b want 0", ver); end
      reset = 1'b0;
      #1;
      checks++; if (hoz !== 1'b1) begin errors++; $display("FAIL sync_rst_hoz: got %b want 1", hoz); end
      checks++; if (ver !== 1'b1) begin errors++; $display("FAIL sync_rst_ver: got %b want 1", ver); end
      checks++; if (col !== 0) begin errors++; $display("FAIL sync_rst_col: got %0d want 0", col); end
      step(2);
      reset = 1'b1;
      step(1);
   endtask

   initial begin
      test_reset;
      test_line;
      test_frame;
`ifndef CRVGA_TEST_PATTERN_EN
      test_colour;
`else
      test_pattern;
`endif
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
